// File: rtl/kp_freq_entry.sv
// Keypad frequency entry: debounces kphit, accumulates up to MAX_DIGITS decimal
// digits and commits the value to the waveform generator on '#'.
//
// state     | meaning
// IDLE      | no key down, waiting for kphit
// PRESS_CNT | kphit high, counting stable cycles before accepting the key
// HELD      | key accepted, waiting for release
// REL_CNT   | kphit low, counting stable cycles before re-arming
module kp_freq_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 3,
  parameter int FREQ_W          = 10
) (
  input  logic              FPGA_CLK1_50,
  input  logic              reset_n,
  input  logic              kphit,
  input  logic [3:0]        kpval,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_valid,
  output logic [FREQ_W-1:0] entry_val,
  output logic [1:0]        digit_cnt,
  output logic              key_err
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      MAXD     = 2'(MAX_DIGITS);
  localparam logic [3:0]      KEY_CLR  = 4'd14;
  localparam logic [3:0]      KEY_ENT  = 4'd15;

  typedef enum logic [1:0] {IDLE, PRESS_CNT, HELD, REL_CNT} state_t;

  state_t           state;
  logic [CNT_W-1:0] db_cnt;
  logic             acc_stb;
  logic [3:0]       acc_key;
  logic [FREQ_W-1:0] next_entry;

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      db_cnt  <= '0;
      acc_stb <= 1'b0;
      acc_key <= 4'd0;
    end else begin
      acc_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (kphit) begin
            state  <= PRESS_CNT;
            db_cnt <= CNT_W'(1);
          end
        end
        PRESS_CNT: begin
          if (!kphit) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt >= CNT_LAST) begin
            // The counter value of this cycle completes the stable window.
            state   <= HELD;
            db_cnt  <= '0;
            acc_stb <= 1'b1;
            acc_key <= kpval;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!kphit) begin
            state  <= REL_CNT;
            db_cnt <= CNT_W'(1);
          end
        end
        REL_CNT: begin
          if (kphit) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt >= CNT_LAST) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // Arithmetic modulo 2^FREQ_W gives the same low bits as the wider product.
  always_comb begin
    next_entry = entry_val * FREQ_W'(10) + FREQ_W'(acc_key);
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      freq_out   <= '0;
      freq_valid <= 1'b0;
      entry_val  <= '0;
      digit_cnt  <= 2'd0;
      key_err    <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      key_err    <= 1'b0;
      if (acc_stb) begin
        if (acc_key <= 4'd9) begin
          if (digit_cnt < MAXD) begin
            entry_val <= next_entry;
            digit_cnt <= digit_cnt + 2'd1;
          end else begin
            key_err <= 1'b1;
          end
        end else if (acc_key == KEY_CLR) begin
          entry_val <= '0;
          digit_cnt <= 2'd0;
        end else if (acc_key == KEY_ENT) begin
          if (digit_cnt != 2'd0 && entry_val != '0) begin
            freq_out   <= entry_val;
            freq_valid <= 1'b1;
          end else begin
            key_err <= 1'b1;
          end
          entry_val <= '0;
          digit_cnt <= 2'd0;
        end else begin
          key_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kp_freq_entry.sv
// Bench for kp_freq_entry: directed scenarios plus random key sequences checked
// against a key-level model of the entry rules.
module tb_kp_freq_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kphit;
  logic [3:0] kpval;
  logic [9:0] freq_out;
  logic       freq_valid;
  logic [9:0] entry_val;
  logic [1:0] digit_cnt;
  logic       key_err;

  int total = 0;
  int bad   = 0;

  // key-level model
  int m_entry = 0;
  int m_cnt   = 0;
  int m_freq  = 0;
  int m_nval  = 0;
  int m_nerr  = 0;

  // pulse monitor
  int  n_val = 0, n_err = 0, n_both = 0, n_long = 0;
  bit  prev_val = 0, prev_err = 0;

  kp_freq_entry #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(3), .FREQ_W(10)) dut (
    .FPGA_CLK1_50(clk),
    .reset_n     (rst_n),
    .kphit       (kphit),
    .kpval       (kpval),
    .freq_out    (freq_out),
    .freq_valid  (freq_valid),
    .entry_val   (entry_val),
    .digit_cnt   (digit_cnt),
    .key_err     (key_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (freq_valid) n_val++;
      if (key_err) n_err++;
      if (freq_valid && key_err) n_both++;
      if ((freq_valid && prev_val) || (key_err && prev_err)) n_long++;
      prev_val = freq_valid;
      prev_err = key_err;
    end else begin
      prev_val = 0;
      prev_err = 0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  function automatic void model_key(input int k);
    if (k <= 9) begin
      if (m_cnt < 3) begin
        m_entry = m_entry * 10 + k;
        m_cnt++;
      end else m_nerr++;
    end else if (k == 14) begin
      m_entry = 0; m_cnt = 0;
    end else if (k == 15) begin
      if (m_cnt > 0 && m_entry != 0) begin
        m_freq = m_entry; m_nval++;
      end else m_nerr++;
      m_entry = 0; m_cnt = 0;
    end else m_nerr++;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // hold >= 4 cycles; when scramble is set kpval wanders once the key is accepted
  task automatic press(input int k, input int hold, input int rel, input bit scramble);
    kpval = 4'(k);
    kphit = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (scramble && i >= 4) kpval = 4'($urandom);
    end
    kphit = 1'b0;
    tick(rel);
    model_key(k);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; kphit = 1'b0; kpval = 4'd0;
    tick(3);
    total++; if (freq_out !== 10'd0) begin bad++; $display("FAIL reset freq_out got=%0d exp=0", freq_out); end
    total++; if (entry_val !== 10'd0) begin bad++; $display("FAIL reset entry_val got=%0d exp=0", entry_val); end
    total++; if (digit_cnt !== 2'd0) begin bad++; $display("FAIL reset digit_cnt got=%0d exp=0", digit_cnt); end
    total++; if ({freq_valid, key_err} !== 2'b00) begin bad++; $display("FAIL reset pulses got=%b exp=00", {freq_valid, key_err}); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_entry;
    int exp_e[3] = '{1, 12, 125};
    int keys[3]  = '{1, 2, 5};
    for (int i = 0; i < 3; i++) begin
      press(keys[i], 10, 10, 0);
      total++; if (entry_val !== 10'(exp_e[i])) begin bad++; $display("FAIL basic entry[%0d] got=%0d exp=%0d", i, entry_val, exp_e[i]); end
      total++; if (digit_cnt !== 2'(i + 1)) begin bad++; $display("FAIL basic cnt[%0d] got=%0d exp=%0d", i, digit_cnt, i + 1); end
    end
    press(15, 10, 10, 0);
    total++; if (freq_out !== 10'd125) begin bad++; $display("FAIL basic freq_out got=%0d exp=125", freq_out); end
    total++; if (n_val !== 1) begin bad++; $display("FAIL basic valid_count got=%0d exp=1", n_val); end
    total++; if (entry_val !== 10'd0 || digit_cnt !== 2'd0) begin bad++; $display("FAIL basic cleared got=%0d/%0d exp=0/0", entry_val, digit_cnt); end
  endtask

  task automatic test_bounce;
    int v0 = n_val, e0 = n_err;
    kpval = 4'd3;
    for (int r = 0; r < 5; r++) begin
      kphit = 1'b1; tick(3);
      kphit = 1'b0; tick(3);
    end
    tick(6);
    total++; if (entry_val !== 10'd0 || digit_cnt !== 2'd0) begin bad++; $display("FAIL bounce entry got=%0d/%0d exp=0/0", entry_val, digit_cnt); end
    total++; if (n_val != v0 || n_err != e0) begin bad++; $display("FAIL bounce pulses got=%0d/%0d exp=%0d/%0d", n_val, n_err, v0, e0); end
    // low glitch while held must not produce a second digit
    kpval = 4'd5; kphit = 1'b1; tick(8);
    kphit = 1'b0; tick(2);
    kphit = 1'b1; tick(8);
    kphit = 1'b0; tick(10);
    model_key(5);
    total++; if (entry_val !== 10'd5 || digit_cnt !== 2'd1) begin bad++; $display("FAIL glitch entry got=%0d/%0d exp=5/1", entry_val, digit_cnt); end
    press(14, 10, 10, 0);
    total++; if (entry_val !== 10'd0 || digit_cnt !== 2'd0) begin bad++; $display("FAIL star clear got=%0d/%0d exp=0/0", entry_val, digit_cnt); end
  endtask

  task automatic test_overflow;
    int e0;
    press(9, 10, 10, 0); press(9, 10, 10, 0); press(9, 10, 10, 0);
    e0 = n_err;
    press(4, 10, 10, 0);
    total++; if (entry_val !== 10'd999 || digit_cnt !== 2'd3) begin bad++; $display("FAIL overflow entry got=%0d/%0d exp=999/3", entry_val, digit_cnt); end
    total++; if (n_err != e0 + 1) begin bad++; $display("FAIL overflow err_count got=%0d exp=%0d", n_err, e0 + 1); end
    press(15, 10, 10, 0);
    total++; if (freq_out !== 10'd999) begin bad++; $display("FAIL overflow freq_out got=%0d exp=999", freq_out); end
  endtask

  task automatic test_clear_commit;
    press(4, 10, 10, 0); press(2, 10, 10, 0);
    press(14, 10, 10, 0);
    total++; if (entry_val !== 10'd0 || digit_cnt !== 2'd0) begin bad++; $display("FAIL clear entry got=%0d/%0d exp=0/0", entry_val, digit_cnt); end
    press(7, 10, 10, 0); press(15, 10, 10, 0);
    total++; if (freq_out !== 10'd7) begin bad++; $display("FAIL clear freq_out got=%0d exp=7", freq_out); end
    total++; if (n_val != m_nval) begin bad++; $display("FAIL clear valid_count got=%0d exp=%0d", n_val, m_nval); end
  endtask

  task automatic test_errors;
    int v0 = n_val, e0 = n_err;
    press(15, 10, 10, 0);
    press(11, 10, 10, 0);
    total++; if (n_err != e0 + 2) begin bad++; $display("FAIL errors err_count got=%0d exp=%0d", n_err, e0 + 2); end
    total++; if (n_val != v0) begin bad++; $display("FAIL errors valid_count got=%0d exp=%0d", n_val, v0); end
    total++; if (freq_out !== 10'd7) begin bad++; $display("FAIL errors freq_out got=%0d exp=7", freq_out); end
    // leading zeros count as digits
    press(0, 10, 10, 0); press(0, 10, 10, 0); press(7, 10, 10, 0);
    total++; if (entry_val !== 10'd7 || digit_cnt !== 2'd3) begin bad++; $display("FAIL zeros entry got=%0d/%0d exp=7/3", entry_val, digit_cnt); end
    press(15, 10, 10, 0);
    // a zero-valued entry is rejected even with digits present
    press(0, 10, 10, 0);
    e0 = n_err;
    press(15, 10, 10, 0);
    total++; if (n_err != e0 + 1 || digit_cnt !== 2'd0) begin bad++; $display("FAIL zero_commit err/cnt got=%0d/%0d exp=%0d/0", n_err, digit_cnt, e0 + 1); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      int k = $urandom_range(0, 15);
      press(k, $urandom_range(6, 12), $urandom_range(6, 12), 1);
      total++; if (entry_val !== 10'(m_entry) || digit_cnt !== 2'(m_cnt)) begin bad++; $display("FAIL random[%0d] key=%0d entry got=%0d/%0d exp=%0d/%0d", n, k, entry_val, digit_cnt, m_entry, m_cnt); end
      total++; if (freq_out !== 10'(m_freq)) begin bad++; $display("FAIL random[%0d] freq_out got=%0d exp=%0d", n, freq_out, m_freq); end
      total++; if (n_val != m_nval || n_err != m_nerr) begin bad++; $display("FAIL random[%0d] pulses got=%0d/%0d exp=%0d/%0d", n, n_val, n_err, m_nval, m_nerr); end
    end
  endtask

  task automatic test_reset_midentry;
    bit seen = 0;
    press(3, 10, 10, 0); press(6, 10, 10, 0);
    kpval = 4'd8; kphit = 1'b1;
    tick(2);
    #3 rst_n = 1'b0;
    #1;
    total++; if (entry_val !== 10'd0 || digit_cnt !== 2'd0 || freq_out !== 10'd0) begin bad++; $display("FAIL midreset async got=%0d/%0d/%0d exp=0/0/0", entry_val, digit_cnt, freq_out); end
    m_entry = 0; m_cnt = 0; m_freq = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(4);
    total++; if (digit_cnt !== 2'd0) begin bad++; $display("FAIL midreset early_accept got=%0d exp=0", digit_cnt); end
    for (int i = 0; i < 6 && !seen; i++) begin
      tick(1);
      if (digit_cnt == 2'd1) seen = 1;
    end
    total++; if (!seen || entry_val !== 10'd8) begin bad++; $display("FAIL midreset accept got=%0d/%0d exp=8/1", entry_val, digit_cnt); end
    kphit = 1'b0; tick(10);
    model_key(8);
    press(15, 10, 10, 0);
    total++; if (freq_out !== 10'd8 || n_val != m_nval) begin bad++; $display("FAIL midreset commit got=%0d/%0d exp=8/%0d", freq_out, n_val, m_nval); end
  endtask

  task automatic test_pulses;
    total++; if (n_both != 0) begin bad++; $display("FAIL pulse_overlap got=%0d exp=0", n_both); end
    total++; if (n_long != 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", n_long); end
  endtask

  initial begin
    test_reset;
    test_basic_entry;
    test_bounce;
    test_overflow;
    test_clear_commit;
    test_errors;
    test_random;
    test_reset_midentry;
    test_pulses;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kp_freq_entry.md
Name: kp_freq_entry

Overview:
- Sits between the keypad decoder and the waveform generator in the function-generator top level.
- Debounces the keypad hit strobe and the decoded 4-bit key code.
- Accumulates up to MAX_DIGITS decimal digits into a frequency entry.
- Presents the committed value to the generator as a held register plus a one-cycle valid pulse.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles kphit must be stable to register a press or a release (10 ms at 50 MHz).
- MAX_DIGITS, 3, maximum decimal digits per entry.
- FREQ_W, 10, width of entry/output value; must hold 10^MAX_DIGITS-1.

Ports:
- FPGA_CLK1_50  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- kphit  input  1  raw key-pressed indicator from keypad decoder, active-high.
- kpval  input  4  decoded key code; valid while kphit=1.
- freq_out  output  FREQ_W  last committed frequency value, held.
- freq_valid  output  1  one-cycle pulse when freq_out updates.
- entry_val  output  FREQ_W  digits entered so far, for display.
- digit_cnt  output  2  number of digits in entry_val (0..MAX_DIGITS).
- key_err  output  1  one-cycle pulse on a rejected key.

Behaviour:
- Reset (async assert, sync deassert usage): freq_out=0, freq_valid=0, entry_val=0, digit_cnt=0, key_err=0, FSM=IDLE, debounce counter=0.
- Key codes: 0-9 are digits; 10-13 (A-D) are unassigned; 14 (*) clears; 15 (#) commits.
- Debounce FSM:
  - IDLE: kphit=1 -> PRESS_CNT, counter=1.
  - PRESS_CNT: kphit=0 -> IDLE, counter=0. counter reaches DEBOUNCE_CYCLES -> HELD; kpval sampled that cycle as the accepted key and an accept strobe is issued for one cycle.
  - HELD: kphit=0 -> REL_CNT, counter=1.
  - REL_CNT: kphit=1 -> HELD, counter=0. counter reaches DEBOUNCE_CYCLES -> IDLE.
  - One accept per physical press. A held key never repeats.
- Entry actions, taken in the cycle after the accept strobe (latency: accept -> register update = 1 cycle):
  - Digit d, digit_cnt<MAX_DIGITS: entry_val = entry_val*10 + d (computed at FREQ_W+4 bits, truncated to FREQ_W); digit_cnt+1.
  - Digit d, digit_cnt==MAX_DIGITS: entry unchanged, key_err=1 for one cycle.
  - *: entry_val=0, digit_cnt=0. Never an error.
  - #, digit_cnt>0 and entry_val!=0: freq_out=entry_val, freq_valid=1 for one cycle, entry_val=0, digit_cnt=0.
  - #, digit_cnt==0 or entry_val==0: freq_out unchanged, no valid pulse, key_err=1, entry cleared.
  - A-D: no change, key_err=1.
- Leading zeros are accepted and counted as digits ("007" then # gives 7).
- freq_valid and key_err are never asserted in the same cycle.
- Each output pulse lasts exactly 1 cycle.
- Reset mid-debounce or mid-entry: all state returns to reset values immediately. A key still held at deassert is treated as a new press and must debounce fully.
- kpval changes while in HELD/REL_CNT are ignored.

Test Plan (DEBOUNCE_CYCLES=4, MAX_DIGITS=3, FREQ_W=10):
1. Press 1, 2, 5, then # (each held 10 cycles, released 10 cycles) -> entry_val 1, 12, 125; freq_out=125 with a single freq_valid pulse; then entry_val=0, digit_cnt=0.
2. kphit high 3 cycles then low (bounce), repeated 5 times -> no accept, entry_val stays 0, no pulses. kphit low-glitch of 2 cycles during HELD -> no second accept.
3. Press 9, 9, 9, 4 -> entry_val=999, key_err pulse on the 4th digit. Then # -> freq_out=999.
4. Press 4, 2, *, 7, # -> entry_val clears to 0 after *; freq_out=7 with valid pulse.
5. Press # with empty entry, then B -> two key_err pulses; freq_out keeps its previous value (e.g. 7); freq_valid never asserts.
6. Enter 3, 6, then assert reset_n=0 for 2 cycles mid-press of 8 -> all outputs 0 asynchronously. After release with kphit still high, 8 is accepted only after 4 stable cycles.
